// File: rtl/dmem_confreg.sv
// dmem_confreg: data-port responder. It serves a word-addressed RAM with byte-masked stores,
// and it decodes a config window that holds the LED register, the switches and a compare timer.
module dmem_confreg #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [15:0] IO_BASE    = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switch_i,
  output logic [15:0] led_o,
  output logic [5:0]  int_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    REG_LED,
    REG_SWITCH,
    REG_COUNT,
    REG_COMPARE,
    REG_STATUS,
    REG_NONE
  } cfg_reg_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  // Request decode
  logic                  io_sel;
  logic [13:0]           word_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  rd_req, wr_req;
  logic                  ram_rd, ram_we, cfg_rd, cfg_we;
  logic                  unused_addr_lsb;
  cfg_reg_e              cfg_sel;

  assign io_sel          = (addr[31:16] == IO_BASE);
  assign word_off        = addr[15:2];
  assign ram_idx         = addr[ADDR_WIDTH+1:2];
  assign unused_addr_lsb = ^addr[1:0];

  assign rd_req = en && (wen == 4'b0000);
  assign wr_req = en && (wen != 4'b0000);
  assign ram_rd = rd_req && !io_sel;
  assign ram_we = wr_req && !io_sel;
  assign cfg_rd = rd_req && io_sel;
  assign cfg_we = wr_req && io_sel;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cfg_sel = REG_NONE;
    case (word_off)
      14'h0000: cfg_sel = REG_LED;
      14'h0001: cfg_sel = REG_SWITCH;
      14'h0002: cfg_sel = REG_COUNT;
      14'h0003: cfg_sel = REG_COMPARE;
      14'h0004: cfg_sel = REG_STATUS;
      default:  cfg_sel = REG_NONE;
    endcase
  end

  // Config registers
  logic [15:0] led, led_next;
  logic [31:0] led_merged;
  logic [31:0] count, count_next, count_inc;
  logic [31:0] compare, compare_next;
  logic        pending, pending_next;
  logic        timer_match, status_clr;
  logic [31:0] cfg_rdata;

  assign count_inc   = count + 32'd1;
  assign led_merged  = lane_merge({16'h0000, led}, wdata, {2'b00, wen[1:0]});
  assign timer_match = (count == compare) && (compare != 32'd0);
  assign status_clr  = cfg_we && (cfg_sel == REG_STATUS) && wen[0] && wdata[0];

  always_comb begin
    led_next     = led;
    count_next   = count_inc;
    compare_next = compare;
    if (cfg_we) begin
      case (cfg_sel)
        REG_LED:     led_next     = led_merged[15:0];
        // A write wins over the increment; lanes that are not written keep the incremented value.
        REG_COUNT:   count_next   = lane_merge(count_inc, wdata, wen);
        REG_COMPARE: compare_next = lane_merge(compare, wdata, wen);
        default:     ;
      endcase
    end
    // A match that sets pending wins over a clear in the same cycle.
    pending_next = timer_match || (pending && !status_clr);
  end

  always_comb begin
    cfg_rdata = 32'h0000_0000;
    case (cfg_sel)
      REG_LED:     cfg_rdata = {16'h0000, led};
      REG_SWITCH:  cfg_rdata = {16'h0000, switch_i};
      REG_COUNT:   cfg_rdata = count;
      REG_COMPARE: cfg_rdata = compare;
      REG_STATUS:  cfg_rdata = {31'h0, pending};
      default:     cfg_rdata = 32'h0000_0000;
    endcase
  end

  // Read path: the RAM word and the config word are captured separately, and a flag records
  // which one the last read used. This way reset can clear rdata while the RAM stays un-reset.
  logic [31:0] cfg_q;
  logic [31:0] ram_q;
  logic        rd_from_ram;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led         <= 16'h0000;
      count       <= 32'h0000_0000;
      compare     <= 32'h0000_0000;
      pending     <= 1'b0;
      cfg_q       <= 32'h0000_0000;
      rd_from_ram <= 1'b0;
    end else begin
      led     <= led_next;
      count   <= count_next;
      compare <= compare_next;
      pending <= pending_next;
      if (cfg_rd) begin
        cfg_q       <= cfg_rdata;
        rd_from_ram <= 1'b0;
      end else if (ram_rd) begin
        rd_from_ram <= 1'b1;
      end
    end
  end

  // Word RAM
  logic [31:0] mem [DEPTH];

  // NOTE: the memory array and its read register have no reset, so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ram_rd) ram_q <= mem[ram_idx];
  end

  assign rdata = rd_from_ram ? ram_q : cfg_q;
  assign led_o = led;
  assign int_o = {pending, 5'b00000};

endmodule
